ecc_rd_checker: RTL and testbench

Pipelined read-side checker for 39-bit inverted-Hamming SECDED codewords produced by the 39/32 encoder on the memory write path. Sits between the ECC-protected RAM read port and the bus response mux. Returns corrected 32-bit data with single- and double-error flags, and keeps error statistics for software.

---
 rtl/ecc_rd_checker_pkg.sv | 61 ++++++
 rtl/ecc_rd_checker_slice.sv | 44 ++++
 rtl/ecc_rd_checker.sv | 133 +++++++++++++
 tb/tb_ecc_rd_checker.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_rd_checker_pkg.sv
// Constants and decode helpers for the 39/32 inverted-Hamming SECDED read checker.
package ecc_rd_checker_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CW_W   = 39;
  localparam int unsigned SYN_W  = 7;

  localparam logic [CW_W-1:0] CW_INV = 39'h2a00000000;

  localparam logic [CW_W-1:0] SYN_MASK_0 = 39'h0056aaad5b;
  localparam logic [CW_W-1:0] SYN_MASK_1 = 39'h009b33366d;
  localparam logic [CW_W-1:0] SYN_MASK_2 = 39'h00e3c3c78e;
  localparam logic [CW_W-1:0] SYN_MASK_3 = 39'h0003fc07f0;
  localparam logic [CW_W-1:0] SYN_MASK_4 = 39'h0003fff800;
  localparam logic [CW_W-1:0] SYN_MASK_5 = 39'h00fc000000;
  localparam logic [CW_W-1:0] SYN_MASK_6 = 39'h3fffffffff;

  localparam logic [SYN_W-1:0][CW_W-1:0] SYN_MASK = {
    SYN_MASK_6, SYN_MASK_5, SYN_MASK_4, SYN_MASK_3,
    SYN_MASK_2, SYN_MASK_1, SYN_MASK_0
  };

  typedef enum logic [1:0] {
    CLEAN  = 2'b00,
    SINGLE = 2'b01,
    DOUBLE = 2'b10
  } err_e;

  // Each syndrome bit also covers its own check bit at position 32+k.
  function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] s;
    for (int k = 0; k < SYN_W; k++) begin
      s[k] = ^(cw & (SYN_MASK[k] | (CW_W'(1) << (DATA_W + k))));
    end
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] flip_mask(input logic [SYN_W-1:0] s);
    logic [DATA_W-1:0] m;
    logic [5:0]        col;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int k = 0; k < 6; k++) begin
        col[k] = SYN_MASK[k][i];
      end
      m[i] = s[6] && (s[5:0] == col);
    end
    return m;
  endfunction

  function automatic err_e classify(input logic [SYN_W-1:0] s);
    if (s == '0) begin
      return CLEAN;
    end
    if (s[6]) begin
      return SINGLE;
    end
    return DOUBLE;
  endfunction

endpackage

// File: rtl/ecc_rd_checker_slice.sv
// Single valid/ready register slice; accepts a new word when empty or draining.
module ecc_rd_checker_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/ecc_rd_checker.sv
// Two-stage SECDED read checker with optional error statistics.
// Statistics are built only when ECC_RD_CHECKER_ERR_LOG_EN is defined.
module ecc_rd_checker
  import ecc_rd_checker_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [38:0]       in_cw_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic [1:0]        out_err_o,
  output logic [CNT_W-1:0]  cnt_single_o,
  output logic [CNT_W-1:0]  cnt_double_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic              err_addr_vld_o,
  input  logic              clr_i
);

  localparam int unsigned S1_W = DATA_W + SYN_W + ADDR_W;
  localparam int unsigned S2_W = DATA_W + 2 + ADDR_W;

  logic [CW_W-1:0]   cw_in;
  logic [S1_W-1:0]   s1_in, s1_q;
  logic              s1_valid, s2_in_ready;
  logic [DATA_W-1:0] s1_data;
  logic [SYN_W-1:0]  s1_syn;
  logic [ADDR_W-1:0] s1_addr, s2_addr;
  err_e              s1_err, s2_err;
  logic [S2_W-1:0]   s2_in, s2_q;

  assign cw_in = in_cw_i ^ CW_INV;
  assign s1_in = {in_addr_i, calc_syndrome(cw_in), cw_in[DATA_W-1:0]};

  ecc_rd_checker_slice #(.W(S1_W)) u_s1 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (s1_in),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_in_ready),
    .out_data_o  (s1_q)
  );

  assign {s1_addr, s1_syn, s1_data} = s1_q;
  assign s1_err = classify(s1_syn);
  // flip_mask is zero unless s[6] is set, so double errors pass through raw.
  assign s2_in  = {s1_addr, s1_err, s1_data ^ flip_mask(s1_syn)};

  ecc_rd_checker_slice #(.W(S2_W)) u_s2 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_in_ready),
    .in_data_i   (s2_in),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (s2_q)
  );

  assign s2_addr    = s2_q[S2_W-1 -: ADDR_W];
  assign s2_err     = err_e'(s2_q[DATA_W +: 2]);
  assign out_data_o = s2_q[DATA_W-1:0];
  assign out_err_o  = s2_err;

`ifdef ECC_RD_CHECKER_ERR_LOG_EN
  logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0]  cnt_double_q, cnt_double_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              err_addr_vld_q, err_addr_vld_d;
  logic              out_hs;

  assign out_hs = out_valid_o && out_ready_i;

  // A clear in the same cycle as a flagged handshake drops that event.
  always_comb begin
    cnt_single_d   = cnt_single_q;
    cnt_double_d   = cnt_double_q;
    err_addr_d     = err_addr_q;
    err_addr_vld_d = err_addr_vld_q;
    if (clr_i) begin
      cnt_single_d   = '0;
      cnt_double_d   = '0;
      err_addr_d     = '0;
      err_addr_vld_d = 1'b0;
    end else if (out_hs && (s2_err != CLEAN)) begin
      if (s2_err == SINGLE) begin
        if (cnt_single_q != '1) cnt_single_d = cnt_single_q + CNT_W'(1);
      end else begin
        if (cnt_double_q != '1) cnt_double_d = cnt_double_q + CNT_W'(1);
      end
      if (!err_addr_vld_q) begin
        err_addr_d     = s2_addr;
        err_addr_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_single_q   <= '0;
      cnt_double_q   <= '0;
      err_addr_q     <= '0;
      err_addr_vld_q <= 1'b0;
    end else begin
      cnt_single_q   <= cnt_single_d;
      cnt_double_q   <= cnt_double_d;
      err_addr_q     <= err_addr_d;
      err_addr_vld_q <= err_addr_vld_d;
    end
  end

  assign cnt_single_o   = cnt_single_q;
  assign cnt_double_o   = cnt_double_q;
  assign err_addr_o     = err_addr_q;
  assign err_addr_vld_o = err_addr_vld_q;
`else
  logic unused_log;
  assign unused_log     = ^{s2_addr, clr_i};
  assign cnt_single_o   = '0;
  assign cnt_double_o   = '0;
  assign err_addr_o     = '0;
  assign err_addr_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_rd_checker.sv
// Directed bench for ecc_rd_checker with a queue-based reference model of the decoder.
module tb_ecc_rd_checker;

  localparam int CNT_W  = 2;
  localparam int ADDR_W = 32;
`ifdef ECC_RD_CHECKER_ERR_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif
  localparam logic [38:0] INV = 39'h2a00000000;
  localparam logic [38:0] MASKS [7] = '{
    39'h0056aaad5b, 39'h009b33366d, 39'h00e3c3c78e, 39'h0003fc07f0,
    39'h0003fff800, 39'h00fc000000, 39'h3fffffffff
  };

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [38:0]       in_cw_i;
  logic [ADDR_W-1:0] in_addr_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_data_o;
  logic [1:0]        out_err_o;
  logic [CNT_W-1:0]  cnt_single_o;
  logic [CNT_W-1:0]  cnt_double_o;
  logic [ADDR_W-1:0] err_addr_o;
  logic              err_addr_vld_o;
  logic              clr_i;

  always #5 clk = ~clk;

  ecc_rd_checker #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_cw_i        (in_cw_i),
    .in_addr_i      (in_addr_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_err_o      (out_err_o),
    .cnt_single_o   (cnt_single_o),
    .cnt_double_o   (cnt_double_o),
    .err_addr_o     (err_addr_o),
    .err_addr_vld_o (err_addr_vld_o),
    .clr_i          (clr_i)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    logic [31:0] addr;
  } exp_t;

  exp_t             q[$];
  exp_t             mon_e;
  logic             mon_hs;
  logic [CNT_W-1:0] m_cs, m_cd;
  logic [31:0]      m_ea;
  logic             m_ev;
  int               n_vec = 0;
  int               n_miss = 0;
  int               n_acc = 0;
  int               n_out = 0;
  int               last_wait = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] m_syn(input logic [38:0] cw);
    logic [6:0]  s;
    logic [38:0] m;
    for (int k = 0; k < 7; k++) begin
      m = MASKS[k];
      m[32+k] = 1'b1;
      s[k] = ^(cw & m);
    end
    return s;
  endfunction

  function automatic logic [38:0] m_encode(input logic [31:0] d);
    logic [6:0]  c;
    logic [38:0] m;
    for (int k = 0; k < 6; k++) begin
      m = MASKS[k];
      c[k] = ^(d & m[31:0]);
    end
    c[6] = ^{c[5:0], d};
    return {c, d} ^ INV;
  endfunction

  // A single error is located by finding the data bit whose flip yields a zero syndrome.
  function automatic exp_t m_decode(input logic [38:0] icw, input logic [31:0] a);
    exp_t        e;
    logic [38:0] cw, t;
    logic [6:0]  s;
    cw = icw ^ INV;
    s = m_syn(cw);
    e.data = cw[31:0];
    e.addr = a;
    if (s == 7'd0) begin
      e.err = 2'b00;
    end else if (s[6]) begin
      e.err = 2'b01;
      for (int i = 0; i < 32; i++) begin
        t = cw;
        t[i] = ~t[i];
        if (m_syn(t) == 7'd0) e.data[i] = ~e.data[i];
      end
    end else begin
      e.err = 2'b10;
    end
    return e;
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst_ni) begin
      q.delete();
      m_cs = '0;
      m_cd = '0;
      m_ea = '0;
      m_ev = 1'b0;
    end else begin
      if (out_valid_o) begin
        if (q.size() == 0) begin
          chk("stale_out_valid", 64'(out_valid_o), 64'd0);
        end else begin
          chk("out_data", 64'(out_data_o), 64'(q[0].data));
          chk("out_err", 64'(out_err_o), 64'(q[0].err));
        end
      end
      chk("cnt_single", 64'(cnt_single_o), 64'(m_cs));
      chk("cnt_double", 64'(cnt_double_o), 64'(m_cd));
      chk("err_addr", 64'(err_addr_o), 64'(m_ea));
      chk("err_addr_vld", 64'(err_addr_vld_o), 64'(m_ev));
      mon_hs = out_valid_o && out_ready_i && (q.size() != 0);
      if (mon_hs) begin
        mon_e = q.pop_front();
        n_out++;
      end
`ifdef ECC_RD_CHECKER_ERR_LOG_EN
      if (clr_i) begin
        m_cs = '0;
        m_cd = '0;
        m_ea = '0;
        m_ev = 1'b0;
      end else if (mon_hs && mon_e.err != 2'b00) begin
        if (mon_e.err == 2'b01) begin
          if (m_cs != '1) m_cs = m_cs + 1'b1;
        end else begin
          if (m_cd != '1) m_cd = m_cd + 1'b1;
        end
        if (!m_ev) begin
          m_ev = 1'b1;
          m_ea = mon_e.addr;
        end
      end
`endif
      if (in_valid_i && in_ready_o) begin
        q.push_back(m_decode(in_cw_i, in_addr_i));
        n_acc++;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [38:0] cw, input logic [31:0] a);
    int t;
    in_valid_i = 1'b1;
    in_cw_i    = cw;
    in_addr_i  = a;
    t = 0;
    @(negedge clk);
    while (!in_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 64'(in_ready_o), 64'd1);
    last_wait = t;
    @(posedge clk);
    #1;
  endtask

  // Sends one beat, then lands on the falling edge where its result is presented.
  task automatic one(input logic [38:0] cw, input logic [31:0] a);
    sync();
    send(cw, a);
    in_valid_i = 1'b0;
    @(negedge clk);
    chk("latency_not_early", 64'(out_valid_o), 64'd0);
    @(negedge clk);
    chk("latency_valid", 64'(out_valid_o), 64'd1);
  endtask

  initial begin
    exp_t e;
    int   base_acc, base_out;
    logic [38:0] cw;

    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    in_cw_i = '0;
    in_addr_i = '0;
    out_ready_i = 1'b1;
    clr_i = 1'b0;

    chk("pin_enc0", 64'(m_encode(32'd0)), 64'h2a00000000);
    chk("pin_enc1", 64'(m_encode(32'd1)), 64'h6900000001);
    e = m_decode(39'h2a00000001, 32'h0);
    chk("pin_dec_single_err", 64'(e.err), 64'd1);
    chk("pin_dec_single_data", 64'(e.data), 64'd0);
    e = m_decode(39'h2a00000003, 32'h0);
    chk("pin_dec_double_err", 64'(e.err), 64'd2);
    chk("pin_dec_double_data", 64'(e.data), 64'd3);

    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_data", 64'(out_data_o), 64'd0);
    chk("rst_out_err", 64'(out_err_o), 64'd0);

    one(39'h2a00000000, 32'h100);
    chk("clean_data", 64'(out_data_o), 64'd0);
    chk("clean_err", 64'(out_err_o), 64'd0);
    @(negedge clk);
    chk("clean_cnt_single", 64'(cnt_single_o), 64'd0);

    one(39'h2a00000001, 32'h104);
    chk("single_data", 64'(out_data_o), 64'd0);
    chk("single_err", 64'(out_err_o), 64'd1);
    @(negedge clk);
    chk("single_cnt", 64'(cnt_single_o), LOG ? 64'd1 : 64'd0);
    chk("single_addr", 64'(err_addr_o), LOG ? 64'h104 : 64'd0);
    chk("single_addr_vld", 64'(err_addr_vld_o), LOG ? 64'd1 : 64'd0);

    one(39'h2a00000003, 32'h108);
    chk("double_err", 64'(out_err_o), 64'd2);
    chk("double_data", 64'(out_data_o), 64'd3);
    @(negedge clk);
    chk("double_cnt", 64'(cnt_double_o), LOG ? 64'd1 : 64'd0);
    chk("double_addr_kept", 64'(err_addr_o), LOG ? 64'h104 : 64'd0);

    sync();
    base_acc = n_acc;
    base_out = n_out;
    out_ready_i = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(m_encode(32'(i)), 32'h200 + 32'(4 * i));
        in_valid_i = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
        chk("bp_accepts", 64'(n_acc - base_acc), 64'd2);
        chk("bp_out_held", 64'(out_valid_o), 64'd1);
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    chk("bp_outputs", 64'(n_out - base_out), 64'd4);

    sync();
    for (int i = 0; i < 4; i++) begin
      send(m_encode(32'hA5A50000 + 32'(i)), 32'h280 + 32'(i));
      chk("thru_no_stall", 64'(last_wait), 64'd0);
    end
    in_valid_i = 1'b0;

    sync();
    for (int i = 0; i < 5; i++) begin
      cw = m_encode(32'h12345678 + 32'(i * 32'h01010101));
      case (i)
        0: cw[0]  = ~cw[0];
        1: cw[7]  = ~cw[7];
        2: cw[31] = ~cw[31];
        3: cw[33] = ~cw[33];
        default: cw[38] = ~cw[38];
      endcase
      send(cw, 32'h2C0 + 32'(i));
    end
    in_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("sat_cnt_single", 64'(cnt_single_o), LOG ? 64'd3 : 64'd0);
    chk("sat_addr_kept", 64'(err_addr_o), LOG ? 64'h104 : 64'd0);

    sync();
    send(m_encode(32'hCAFE0000) ^ 39'h10, 32'h2F0);
    in_valid_i = 1'b0;
    sync();
    chk("clr_on_handshake", 64'(out_valid_o), 64'd1);
    clr_i = 1'b1;
    sync();
    clr_i = 1'b0;
    @(negedge clk);
    chk("clr_cnt_single", 64'(cnt_single_o), 64'd0);
    chk("clr_cnt_double", 64'(cnt_double_o), 64'd0);
    chk("clr_addr_vld", 64'(err_addr_vld_o), 64'd0);

    one(m_encode(32'h0BADF00D) ^ 39'h400, 32'h300);
    @(negedge clk);
    chk("recapture_addr", 64'(err_addr_o), LOG ? 64'h300 : 64'd0);
    chk("recapture_vld", 64'(err_addr_vld_o), LOG ? 64'd1 : 64'd0);

    sync();
    send(m_encode(32'h11110000) ^ 39'h1, 32'h400);
    send(m_encode(32'h22220000), 32'h404);
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    sync();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
    chk("midrst_in_ready", 64'(in_ready_o), 64'd1);
    chk("midrst_cnt_single", 64'(cnt_single_o), 64'd0);
    chk("midrst_addr_vld", 64'(err_addr_vld_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(out_valid_o), 64'd0);
    end

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got time %0t, expected under 200000", $time);
    $fatal(1);
  end

endmodule
